feistel_cipher_iter: RTL and testbench
======================================

Name: feistel_cipher_iter

Overview:
- Parametrised, iterative successor to the single-round 8-bit encryptor: an N-round balanced Feistel cipher over 2*HALF_W-bit blocks, one round per clock.
- Generalised in width and round count. Adds encrypt/decrypt mode, an on-the-fly rotating key schedule and valid/ready handshakes on input and output.
- Sits between a data source and sink in the lab crypto datapath.

Parameters:
- HALF_W, 4, half-block width in bits; the block is W = 2*HALF_W bits (legal: HALF_W >= 2).
- NUM_ROUNDS, 4, number of Feistel rounds (legal: >= 1).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  in_data/in_key/in_mode are valid
- in_ready  out  1  block can accept a new job
- in_data  in  W  plaintext (mode=0) or ciphertext (mode=1)
- in_key  in  W  cipher key
- in_mode  in  1  0 = encrypt, 1 = decrypt
- out_valid  out  1  out_data holds a finished result
- out_ready  in  1  sink accepts out_data
- out_data  out  W  result
- busy  out  1  state != IDLE

Behaviour:
- Reset:
  - Asynchronous, active-high; takes effect immediately, mid-job included; the job is discarded.
  - State=IDLE, round counter=0, L/R/key/mode registers=0.
  - out_valid=0, out_data=0, busy=0, in_ready=1.
- Definitions (all modulo 2^HALF_W, W-bit rotates):
  - E(R) = {rotl(R,1), R}, a W-bit value.
  - F(R,K) = A + B + K[0], where {A,B} = E(R) ^ K and A is the upper half.
  - Round key k_i = rotl(key, i mod W) for i = 0..NUM_ROUNDS-1.
  - Encrypt round i uses k_i. Decrypt round i uses k_{NUM_ROUNDS-1-i}.
  - Round step: L' = R, R' = L ^ F(R, k). Result = {R_N, L_N}, i.e. the last swap is undone, so decrypt(encrypt(x)) == x.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid=1 at an edge: capture L=in_data[W-1:HALF_W], R=in_data[HALF_W-1:0], key, mode; counter=0; go to RUN. All inputs are sampled only at this edge; later changes are ignored.
  - RUN: one round per edge, counter increments. After the edge that performs round NUM_ROUNDS-1, go to DONE and register out_data={R,L}.
  - DONE: out_valid=1; out_data held stable while out_ready=0. On out_ready=1 at an edge: out_valid->0, go to IDLE.
- Latency: the accepting edge is T. out_valid is high after edge T+NUM_ROUNDS. Minimum job period is NUM_ROUNDS+2 cycles (with out_ready tied high).
- Ready/valid rules:
  - in_ready is a pure function of state; there is no combinational path from out_ready or in_valid.
  - in_valid in RUN or DONE is ignored (in_ready=0).
  - out_ready in IDLE or RUN is ignored.
  - out_data holds its last value after the handshake until the next job completes.
- Counter: $clog2(NUM_ROUNDS) bits, minimum 1. NUM_ROUNDS=1 must work: RUN lasts exactly 1 cycle.
- Key rotation for i >= W wraps modulo W.

Decomposition:
- Package feistel_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - functions rotl, expand (E) and round_f (F), parametrised through HALF_W arguments.
- Sub-module feistel_round: combinational one-round step with inputs L, R, round key and outputs L', R'. Instantiate once in the iterative datapath.
- Key schedule is computed from the captured key and the counter/mode; the rotated key is not stored per round.

Test Plan:
- Reset during RUN (assert at round 2) -> out_valid=0 and in_ready=1 immediately; the next job produces the correct result.
- HALF_W=4, NUM_ROUNDS=1: encrypt in_data=0x46, key=0x93 -> out_data=0xF6 one cycle after accept. Decrypt 0xF6 with key 0x93 -> 0x46.
- Defaults (HALF_W=4, NUM_ROUNDS=4): encrypt 0x46 with key 0x93 -> 0x3D, out_valid 4 cycles after the accepting edge. Decrypt 0x3D with key 0x93 -> 0x46.
- Defaults: encrypt 0x00 with key 0x00 -> 0x00. Random 200 pairs: decrypt(encrypt(x,k),k)==x. Repeat with HALF_W=8, NUM_ROUNDS=10.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and toggle in_data/in_valid -> out_data stays 0x3D, in_ready=0, no new job accepted. out_ready=1 -> IDLE next cycle.
- Back-to-back jobs with in_valid and out_ready held high -> accept edges spaced exactly NUM_ROUNDS+2 cycles apart and no result is lost or duplicated.

Source files
------------

// File: rtl/feistel_pkg.sv
// Shared types and arithmetic helpers for the iterative Feistel cipher.
// Helpers work on a fixed 64-bit carrier word; the active width is passed
// as an argument, so one set of functions serves every HALF_W up to 32.
package feistel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] word_t;

    // Low w bits set; w == MAX_W wraps to all ones.
    function automatic word_t mask_w(input int w);
        return (word_t'(1) << w) - word_t'(1);
    endfunction

    // Rotate the low w bits of x left by n (n taken modulo w).
    function automatic word_t rotl(input word_t x, input int n, input int w);
        word_t xm;
        int    sh;
        xm = x & mask_w(w);
        sh = n % w;
        // With sh == 0 the right shift by w yields zero, so no special case.
        return ((xm << sh) | (xm >> (w - sh))) & mask_w(w);
    endfunction

    // E(R) = {rotl(R,1), R}, 2*half_w bits wide.
    function automatic word_t expand(input word_t r, input int half_w);
        return (rotl(r, 1, half_w) << half_w) | (r & mask_w(half_w));
    endfunction

    // F(R,K) = A + B + K[0] (mod 2^half_w), {A,B} = E(R) ^ K.
    function automatic word_t round_f(input word_t r, input word_t k, input int half_w);
        word_t e;
        e = expand(r, half_w) ^ k;
        return (((e >> half_w) & mask_w(half_w)) + (e & mask_w(half_w)) + word_t'(k[0]))
               & mask_w(half_w);
    endfunction

endpackage

// File: rtl/feistel_round.sv
// One combinational Feistel round: L' = R, R' = L ^ F(R, K).
// Ports: l_in/r_in (half-block inputs), round_key (full-width key),
//        l_out/r_out (half-block outputs). Purely combinational.
module feistel_round
    import feistel_pkg::*;
#(
    parameter int HALF_W = 4
) (
    input  logic [HALF_W-1:0]   l_in,
    input  logic [HALF_W-1:0]   r_in,
    input  logic [2*HALF_W-1:0] round_key,
    output logic [HALF_W-1:0]   l_out,
    output logic [HALF_W-1:0]   r_out
);

    assign l_out = r_in;
    assign r_out = l_in ^ HALF_W'(round_f(word_t'(r_in), word_t'(round_key), HALF_W));

endmodule

// File: rtl/feistel_cipher_iter.sv
// Iterative N-round balanced Feistel cipher, one round per clock, enc/dec.
// Ports: clock/reset (async active-high), in_valid/in_ready/in_data/in_key/
//        in_mode job input, out_valid/out_ready/out_data result, busy status.
// Result valid NUM_ROUNDS edges after accept; holds in DONE until out_ready.
module feistel_cipher_iter
    import feistel_pkg::*;
#(
    parameter int HALF_W     = 4,
    parameter int NUM_ROUNDS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*HALF_W-1:0] in_data,
    input  logic [2*HALF_W-1:0] in_key,
    input  logic                in_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*HALF_W-1:0] out_data,
    output logic                busy
);

    localparam int W     = 2 * HALF_W;
    localparam int CNT_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [HALF_W-1:0]  l_q,     l_d;
    logic [HALF_W-1:0]  r_q,     r_d;
    logic [W-1:0]       key_q,   key_d;
    logic               mode_q,  mode_d;
    logic [W-1:0]       out_q,   out_d;

    logic [HALF_W-1:0]  l_nx, r_nx;
    logic [W-1:0]       round_key;
    int                 ridx;
    logic               last_round;

    // Round key derived from the captured key every cycle; decrypt walks
    // the schedule backwards so the same round hardware inverts itself.
    always_comb begin
        ridx      = mode_q ? (NUM_ROUNDS - 1 - int'(cnt_q)) : int'(cnt_q);
        round_key = W'(rotl(word_t'(key_q), ridx % W, W));
    end

    assign last_round = (cnt_q == CNT_W'(NUM_ROUNDS - 1));

    feistel_round #(.HALF_W(HALF_W)) u_round (
        .l_in      (l_q),
        .r_in      (r_q),
        .round_key (round_key),
        .l_out     (l_nx),
        .r_out     (r_nx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        l_d     = l_q;
        r_d     = r_q;
        key_d   = key_q;
        mode_d  = mode_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    l_d     = in_data[W-1:HALF_W];
                    r_d     = in_data[HALF_W-1:0];
                    key_d   = in_key;
                    mode_d  = in_mode;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                l_d   = l_nx;
                r_d   = r_nx;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_round) begin
                    // Final swap undone: result is {R_N, L_N}.
                    out_d   = {r_nx, l_nx};
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            l_q     <= '0;
            r_q     <= '0;
            key_q   <= '0;
            mode_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            l_q     <= l_d;
            r_q     <= r_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_q;

endmodule

// File: tb/tb_feistel_cipher_iter.sv
module tb_feistel_cipher_iter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  d_valid, d_mode, d_ready;
    logic [15:0] d_data [3];
    logic [15:0] d_key  [3];
    wire  [2:0]  i_ready, o_valid, o_busy;
    wire  [7:0]  o_data0, o_data1;
    wire  [15:0] o_data2;

    int checks = 0;
    int errors = 0;

    // Instance 0: defaults, 1: HALF_W=4/NUM_ROUNDS=1, 2: HALF_W=8/NUM_ROUNDS=10
    int hw_of [3] = '{4, 4, 8};
    int nr_of [3] = '{4, 1, 10};

    always #5 clock = ~clock;

    feistel_cipher_iter dut0 (
        .clock(clock), .reset(reset),
        .in_valid(d_valid[0]), .in_ready(i_ready[0]), .in_data(d_data[0][7:0]),
        .in_key(d_key[0][7:0]), .in_mode(d_mode[0]), .out_valid(o_valid[0]),
        .out_ready(d_ready[0]), .out_data(o_data0), .busy(o_busy[0])
    );

    feistel_cipher_iter #(.HALF_W(4), .NUM_ROUNDS(1)) dut1 (
        .clock(clock), .reset(reset),
        .in_valid(d_valid[1]), .in_ready(i_ready[1]), .in_data(d_data[1][7:0]),
        .in_key(d_key[1][7:0]), .in_mode(d_mode[1]), .out_valid(o_valid[1]),
        .out_ready(d_ready[1]), .out_data(o_data1), .busy(o_busy[1])
    );

    feistel_cipher_iter #(.HALF_W(8), .NUM_ROUNDS(10)) dut2 (
        .clock(clock), .reset(reset),
        .in_valid(d_valid[2]), .in_ready(i_ready[2]), .in_data(d_data[2]),
        .in_key(d_key[2]), .in_mode(d_mode[2]), .out_valid(o_valid[2]),
        .out_ready(d_ready[2]), .out_data(o_data2), .busy(o_busy[2])
    );

    // ---------------- reference model (plain integer arithmetic) ----------
    function automatic int rot(input int x, input int n, input int w);
        int s;
        s = n % w;
        if (s == 0) return x;
        return ((x << s) | (x >> (w - s))) & ((1 << w) - 1);
    endfunction

    function automatic int model(input int hw, input int nr, input int data,
                                 input int key, input int mode);
        int w, hm, l, r, k, e, f, t, ki;
        w  = 2 * hw;
        hm = (1 << hw) - 1;
        l  = (data >> hw) & hm;
        r  = data & hm;
        for (int i = 0; i < nr; i++) begin
            ki = (mode != 0) ? (nr - 1 - i) : i;
            k  = rot(key, ki, w);
            e  = ((rot(r, 1, hw) << hw) | r) ^ k;
            f  = ((e >> hw) + (e & hm) + (k & 1)) & hm;
            t  = l ^ f;
            l  = r;
            r  = t;
        end
        return (r << hw) | l;
    endfunction

    function automatic int get_out(input int inst);
        case (inst)
            0:       return int'(o_data0);
            1:       return int'(o_data1);
            default: return int'(o_data2);
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic start_job(input int inst, input int data, input int key, input int mode);
        int g = 0;
        while (!i_ready[inst] && g < 200) begin
            @(posedge clock); #1; g++;
        end
        chk("in_ready_before_accept", int'(i_ready[inst]), 1);
        d_data[inst]  = 16'(data);
        d_key[inst]   = 16'(key);
        d_mode[inst]  = mode[0];
        d_valid[inst] = 1'b1;
        @(posedge clock); #1;
        d_valid[inst] = 1'b0;
    endtask

    task automatic wait_done(input int inst, output int lat);
        lat = 0;
        while (!o_valid[inst] && lat < 200) begin
            @(posedge clock); #1; lat++;
        end
        chk("out_valid_reached", int'(o_valid[inst]), 1);
    endtask

    task automatic run_job(input int inst, input int data, input int key, input int mode,
                           output int res, output int lat);
        start_job(inst, data, key, mode);
        wait_done(inst, lat);
        res = get_out(inst);
        d_ready[inst] = 1'b1;
        @(posedge clock); #1;
        d_ready[inst] = 1'b0;
    endtask

    initial begin
        int res, lat, x, k, enc, mask, n;
        int acc_cyc[$];
        int exp_q[$];
        int got_q[$];
        int cyc;
        logic acc;

        d_valid = '0; d_mode = '0; d_ready = '0;
        for (int i = 0; i < 3; i++) begin
            d_data[i] = '0;
            d_key[i]  = '0;
        end

        // ---- reset state ----
        #2;
        chk("rst_out_valid", int'(o_valid), 0);
        chk("rst_in_ready", int'(i_ready), 7);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_out_data", int'(o_data0), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // ---- single round instance ----
        run_job(1, 'h46, 'h93, 0, res, lat);
        chk("nr1_enc", res, 'hF6);
        chk("nr1_enc_model", res, model(4, 1, 'h46, 'h93, 0));
        chk("nr1_lat", lat, 1);
        run_job(1, 'hF6, 'h93, 1, res, lat);
        chk("nr1_dec", res, 'h46);

        // ---- defaults: directed vectors ----
        run_job(0, 'h46, 'h93, 0, res, lat);
        chk("def_enc", res, 'h3D);
        chk("def_enc_model", res, model(4, 4, 'h46, 'h93, 0));
        chk("def_lat", lat, 4);
        run_job(0, 'h3D, 'h93, 1, res, lat);
        chk("def_dec", res, 'h46);
        run_job(0, 'h00, 'h00, 0, res, lat);
        chk("def_zero", res, 'h00);

        // ---- reset during RUN ----
        start_job(0, 'h46, 'h93, 0);
        @(posedge clock);
        @(posedge clock);
        #3;
        chk("mid_busy_before_reset", int'(o_busy[0]), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", int'(o_valid[0]), 0);
        chk("mid_rst_in_ready", int'(i_ready[0]), 1);
        chk("mid_rst_busy", int'(o_busy[0]), 0);
        chk("mid_rst_out_data", int'(o_data0), 0);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        x = int'($urandom_range(0, 255));
        k = int'($urandom_range(0, 255));
        run_job(0, x, k, 0, res, lat);
        chk("post_rst_job", res, model(4, 4, x, k, 0));

        // ---- backpressure in DONE ----
        start_job(0, 'h46, 'h93, 0);
        wait_done(0, lat);
        for (int c = 0; c < 5; c++) begin
            d_valid[0] = 1'($urandom_range(0, 1));
            d_data[0]  = 16'($urandom_range(0, 255));
            chk("bp_out_data", int'(o_data0), 'h3D);
            chk("bp_in_ready", int'(i_ready[0]), 0);
            chk("bp_out_valid", int'(o_valid[0]), 1);
            @(posedge clock); #1;
        end
        chk("bp_out_data_end", int'(o_data0), 'h3D);
        d_valid[0] = 1'b0;
        d_ready[0] = 1'b1;
        @(posedge clock); #1;
        d_ready[0] = 1'b0;
        chk("bp_idle_in_ready", int'(i_ready[0]), 1);
        chk("bp_idle_busy", int'(o_busy[0]), 0);
        chk("bp_idle_out_valid", int'(o_valid[0]), 0);
        chk("bp_hold_after_hs", int'(o_data0), 'h3D);

        // ---- random round trips, both widths ----
        foreach (hw_of[inst]) begin
            if (inst == 1) continue;
            mask = (1 << (2 * hw_of[inst])) - 1;
            for (int t = 0; t < 200; t++) begin
                x = int'($urandom) & mask;
                k = int'($urandom) & mask;
                run_job(inst, x, k, 0, enc, lat);
                chk("rnd_enc", enc, model(hw_of[inst], nr_of[inst], x, k, 0));
                chk("rnd_lat", lat, nr_of[inst]);
                run_job(inst, enc, k, 1, res, lat);
                chk("rnd_roundtrip", res, x);
            end
        end

        // ---- back-to-back with in_valid and out_ready held high ----
        cyc = 0;
        d_ready[0] = 1'b1;
        d_valid[0] = 1'b1;
        d_data[0]  = 16'($urandom_range(0, 255));
        d_key[0]   = 16'($urandom_range(0, 255));
        d_mode[0]  = 1'($urandom_range(0, 1));
        while (acc_cyc.size() < 5 && cyc < 300) begin
            if (o_valid[0]) got_q.push_back(int'(o_data0));
            acc = i_ready[0];
            if (acc) begin
                exp_q.push_back(model(4, 4, int'(d_data[0]), int'(d_key[0]), int'(d_mode[0])));
                acc_cyc.push_back(cyc);
            end
            @(posedge clock); #1; cyc++;
            if (acc) begin
                d_data[0] = 16'($urandom_range(0, 255));
                d_key[0]  = 16'($urandom_range(0, 255));
                d_mode[0] = 1'($urandom_range(0, 1));
            end
        end
        d_valid[0] = 1'b0;
        while (got_q.size() < exp_q.size() && cyc < 600) begin
            if (o_valid[0]) got_q.push_back(int'(o_data0));
            @(posedge clock); #1; cyc++;
        end
        d_ready[0] = 1'b0;
        chk("b2b_accepts", acc_cyc.size(), 5);
        chk("b2b_results", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk("b2b_data", got_q[i], exp_q[i]);
        for (int i = 1; i < acc_cyc.size(); i++)
            chk("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
